vga_fb_fetch_sched: RTL and testbench
=====================================

Name: vga_fb_fetch_sched

Overview:
- Schedules the single-port framebuffer SRAM between two requesters: display line prefetch and CPU writes.
- Display prefetch is driven by the vertical sequencer's addr_y/addr_y_valid. It fetches one scanline of words into a double-banked line buffer one line ahead of display.
- Display has priority. The CPU is guaranteed one slot every CPU_SLOT_PERIOD cycles during a fetch burst.

Parameters:
ADDR_WIDTH, 18, SRAM word address width
DATA_WIDTH, 16, SRAM/line-buffer word width
ADDR_Y_WIDTH, 9, width of addr_y
LINES, 480, visible lines per frame
WORDS_PER_LINE, 40, words fetched per scanline (>=2)
FB_BASE, 0, SRAM word address of line 0
MEM_RD_LATENCY, 2, cycles from read issue to valid mem_rdata (>=1)
CPU_SLOT_PERIOD, 4, every Nth burst cycle is offered to the CPU (>=2)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
addr_y_valid  in  1  current line visible (from vertical sequencer)
addr_y  in  ADDR_Y_WIDTH  current visible line
disp_bank  out  1  line-buffer bank to display (= addr_y[0])
lb_we  out  1  line-buffer write strobe
lb_bank  out  1  bank for lb write
lb_addr  out  $clog2(WORDS_PER_LINE)  word index in line
lb_wdata  out  DATA_WIDTH  fetched word
mem_ce  out  1  SRAM access this cycle
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_WIDTH  SRAM address
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_rdata  in  DATA_WIDTH  SRAM read data, MEM_RD_LATENCY after read
cpu_valid  in  1  CPU write request
cpu_ready  out  1  CPU write accepted this cycle (combinational)
cpu_addr  in  ADDR_WIDTH  CPU write address
cpu_wdata  in  DATA_WIDTH  CPU write data
fetch_busy  out  1  display fetch in FETCH or DRAIN
overrun_err  out  1  sticky: new trigger arrived before previous fetch completed

Behaviour:
- Reset (async): state IDLE; all strobes 0; the addr_y/valid history registers clear to 0; overrun_err=0; read pipeline flushed. Reset mid-burst discards all in-flight reads; no lb_we follows.
- Triggers, evaluated on registered history (valid_d, y_d):
  - New line: addr_y_valid & (!valid_d | addr_y!=y_d). Fetch line addr_y+1 into bank (addr_y+1)[0]. If addr_y==LINES-1, no fetch.
  - Frame end: valid_d & !addr_y_valid. Fetch line 0 into bank 0.
- A trigger in FETCH or DRAIN sets overrun_err. It abandons the old fetch: pipeline entries for the old line are squashed (no lb_we) and FETCH restarts at idx 0 for the new line.
- State machine:
  - IDLE: on trigger -> FETCH. Latch line_base = FB_BASE + y*WORDS_PER_LINE (truncated to ADDR_WIDTH) and bank. Clear idx and slot counter.
  - FETCH: slot counter counts 0..CPU_SLOT_PERIOD-1 and wraps, advancing every cycle.
    - At count==CPU_SLOT_PERIOD-1 with cpu_valid: CPU write is granted.
    - Otherwise: display read of line_base+idx; idx++.
    - When the read with idx==WORDS_PER_LINE-1 is issued -> DRAIN.
  - DRAIN: wait until the read pipeline is empty -> IDLE.
- CPU arbitration: cpu_ready=1 in IDLE and DRAIN, and on FETCH CPU slots; otherwise 0.
  - On cpu_valid&cpu_ready: mem_ce=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, same cycle.
- Display read issue: mem_ce=1, mem_we=0.
- Read return: a shift pipeline of {valid, idx, bank} with depth MEM_RD_LATENCY. On exit it drives lb_we=1, lb_addr=idx, lb_bank=bank, lb_wdata=mem_rdata.
- Burst length: WORDS_PER_LINE reads plus the granted CPU slots; last lb_we is MEM_RD_LATENCY after the last read.
- disp_bank registered: addr_y[0] when addr_y_valid, else 0.
- fetch_busy=1 in FETCH/DRAIN.

Test Plan:
- Reset then addr_y_valid 0->1 with addr_y=0, cpu_valid=0 -> 40 reads at addresses 40..79, consecutive cycles; lb_we on bank 1, idx 0..39, each 2 cycles after its read; fetch_busy drops after the last write.
- Fetch with cpu_valid held 1, cpu_addr=0x100 -> cpu_ready every 4th burst cycle; 40 reads + 13 CPU writes; burst spans 53 cycles; no read skipped or repeated.
- addr_y=479 new line -> no fetch. Then addr_y_valid 1->0 -> line 0 fetched (addresses 0..39) into bank 0.
- Change addr_y 5->6 while fetch of line 6 is at idx 10 -> overrun_err=1 sticky; old in-flight reads produce no lb_we; line 7 fetched from idx 0 into bank 1.
- Assert reset for 1 cycle mid-FETCH -> all outputs 0 immediately; no further lb_we; next trigger fetches normally.
- Idle, cpu_valid=1 continuously -> cpu_ready=1 every cycle; mem_we=1, mem_addr follows cpu_addr.

Source files
------------

// File: rtl/vga_fb_fetch_sched.sv
// Framebuffer SRAM scheduler: prefetches the next display scanline into a double-banked
// line buffer and interleaves CPU writes, with one guaranteed CPU slot per slot period.
module vga_fb_fetch_sched #(
  parameter int unsigned ADDR_WIDTH      = 18,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_Y_WIDTH    = 9,
  parameter int unsigned LINES           = 480,
  parameter int unsigned WORDS_PER_LINE  = 40,
  parameter int unsigned FB_BASE         = 0,
  parameter int unsigned MEM_RD_LATENCY  = 2,
  parameter int unsigned CPU_SLOT_PERIOD = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              addr_y_valid,
  input  logic [ADDR_Y_WIDTH-1:0]           addr_y,
  output logic                              disp_bank,
  output logic                              lb_we,
  output logic                              lb_bank,
  output logic [$clog2(WORDS_PER_LINE)-1:0] lb_addr,
  output logic [DATA_WIDTH-1:0]             lb_wdata,
  output logic                              mem_ce,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              cpu_valid,
  output logic                              cpu_ready,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_wdata,
  output logic                              fetch_busy,
  output logic                              overrun_err
);

  localparam int unsigned IdxW  = $clog2(WORDS_PER_LINE);
  localparam int unsigned SlotW = $clog2(CPU_SLOT_PERIOD);
  localparam int unsigned Lat   = MEM_RD_LATENCY;

  localparam logic [IdxW-1:0]         LastIdx  = IdxW'(WORDS_PER_LINE - 1);
  localparam logic [SlotW-1:0]        LastSlot = SlotW'(CPU_SLOT_PERIOD - 1);
  localparam logic [ADDR_Y_WIDTH-1:0] LastLine = ADDR_Y_WIDTH'(LINES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e state_q, state_d;

  logic                    valid_q;
  logic [ADDR_Y_WIDTH-1:0] y_q;
  logic                    new_line, frame_end, trig;
  logic [ADDR_Y_WIDTH-1:0] fetch_y;
  logic [ADDR_WIDTH-1:0]   new_base;

  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    bank_q;
  logic [IdxW-1:0]         idx_q;
  logic [SlotW-1:0]        slot_q;

  logic cpu_slot, cpu_grant, read_issue, pipe_pending;

  logic [Lat-1:0]  pv_q;
  logic [Lat-1:0]  pbank_q;
  logic [IdxW-1:0] pidx_q [Lat];

  // Triggers compare live inputs against last cycle's history.
  assign new_line  = addr_y_valid & (~valid_q | (addr_y != y_q));
  assign frame_end = valid_q & ~addr_y_valid;
  assign trig      = (new_line & (addr_y != LastLine)) | frame_end;
  assign fetch_y   = frame_end ? '0 : addr_y + ADDR_Y_WIDTH'(1);
  assign new_base  = ADDR_WIDTH'(FB_BASE) + ADDR_WIDTH'(fetch_y) * ADDR_WIDTH'(WORDS_PER_LINE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      y_q         <= '0;
      disp_bank   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      valid_q     <= addr_y_valid;
      y_q         <= addr_y;
      disp_bank   <= addr_y_valid & addr_y[0];
      overrun_err <= overrun_err | (trig & (state_q != StIdle));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      bank_q <= 1'b0;
      idx_q  <= '0;
      slot_q <= '0;
    end else if (trig) begin
      base_q <= new_base;
      bank_q <= fetch_y[0];
      idx_q  <= '0;
      slot_q <= '0;
    end else if (state_q == StFetch) begin
      slot_q <= (slot_q == LastSlot) ? '0 : slot_q + SlotW'(1);
      if (read_issue) idx_q <= idx_q + IdxW'(1);
    end
  end

  // Read-return pipeline; a trigger flushes every entry belonging to the abandoned line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q    <= '0;
      pbank_q <= '0;
      for (int unsigned i = 0; i < Lat; i++) pidx_q[i] <= '0;
    end else begin
      pv_q[0]    <= read_issue;
      pidx_q[0]  <= idx_q;
      pbank_q[0] <= bank_q;
      for (int unsigned i = 1; i < Lat; i++) begin
        pv_q[i]    <= pv_q[i-1] & ~trig;
        pidx_q[i]  <= pidx_q[i-1];
        pbank_q[i] <= pbank_q[i-1];
      end
    end
  end

  // Entries that will still be in flight after this edge.
  always_comb begin
    pipe_pending = 1'b0;
    for (int unsigned i = 0; i + 1 < Lat; i++) pipe_pending = pipe_pending | pv_q[i];
  end

  assign lb_we    = pv_q[Lat-1] & ~trig;
  assign lb_addr  = pidx_q[Lat-1];
  assign lb_bank  = pbank_q[Lat-1];
  assign lb_wdata = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = StFetch;
    end else begin
      case (state_q)
        StFetch: if (read_issue && (idx_q == LastIdx)) state_d = StDrain;
        StDrain: if (!pipe_pending) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_slot   = 1'b0;
    cpu_ready  = 1'b0;
    read_issue = 1'b0;
    fetch_busy = 1'b0;
    case (state_q)
      StIdle: cpu_ready = 1'b1;
      StFetch: begin
        fetch_busy = 1'b1;
        cpu_slot   = (slot_q == LastSlot);
        cpu_ready  = cpu_slot;
        read_issue = ~(cpu_slot & cpu_valid) & ~trig;
      end
      StDrain: begin
        fetch_busy = 1'b1;
        cpu_ready  = 1'b1;
      end
      default: ;
    endcase
    cpu_grant = cpu_valid & cpu_ready;
    mem_ce    = cpu_grant | read_issue;
    mem_we    = cpu_grant;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (read_issue) begin
      mem_addr = base_q + ADDR_WIDTH'(idx_q);
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch_sched.sv
// Directed bench for vga_fb_fetch_sched with a 2-cycle-latency SRAM model whose read
// data is a fixed function of the address.
module tb_vga_fb_fetch_sched;

  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 16;
  localparam int unsigned YW  = 9;
  localparam int unsigned WPL = 40;
  localparam int unsigned IW  = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          addr_y_valid = 1'b0;
  logic [YW-1:0] addr_y = '0;
  logic          disp_bank, lb_we, lb_bank;
  logic [IW-1:0] lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          fetch_busy, overrun_err;
  logic [DW-1:0] rd1 = '0;
  logic [DW-1:0] rd2 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_fb_fetch_sched dut (
    .clk          (clk),
    .reset        (reset),
    .addr_y_valid (addr_y_valid),
    .addr_y       (addr_y),
    .disp_bank    (disp_bank),
    .lb_we        (lb_we),
    .lb_bank      (lb_bank),
    .lb_addr      (lb_addr),
    .lb_wdata     (lb_wdata),
    .mem_ce       (mem_ce),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .cpu_valid    (cpu_valid),
    .cpu_ready    (cpu_ready),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .fetch_busy   (fetch_busy),
    .overrun_err  (overrun_err)
  );

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    rd1 <= mem_fn(mem_addr);
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in the trigger cycle; k counts cycles from the first FETCH cycle.
  task automatic burst(input string tag, input logic [AW-1:0] base, input logic bank,
                       input bit cpu_on, input int span, input int n_cpu_exp);
    int issued[$];
    int r = 0;
    int n_rd = 0;
    int n_lb = 0;
    int n_cpu = 0;
    bit slot, exp_we;
    for (int k = 0; k < span + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      slot = (k % 4) == 3;
      if (mem_ce && !mem_we) n_rd++;
      if (lb_we) n_lb++;
      if (k < span) begin
        if (mem_ce && mem_we) n_cpu++;
        check($sformatf("%s_busy_k%0d", tag, k), fetch_busy, 1);
        check($sformatf("%s_rdy_k%0d", tag, k), cpu_ready, slot);
        if (cpu_on && slot) begin
          check($sformatf("%s_cwe_k%0d", tag, k), mem_we, 1);
          check($sformatf("%s_caddr_k%0d", tag, k), mem_addr, 32'h100);
          check($sformatf("%s_cdata_k%0d", tag, k), mem_wdata, 32'h00C3);
          issued.push_back(-1);
        end else begin
          check($sformatf("%s_ce_k%0d", tag, k), mem_ce, 1);
          check($sformatf("%s_we_k%0d", tag, k), mem_we, 0);
          check($sformatf("%s_addr_k%0d", tag, k), mem_addr, base + AW'(r));
          issued.push_back(r);
          r++;
        end
      end else begin
        check($sformatf("%s_busy_k%0d", tag, k), fetch_busy, k < span + 2);
        check($sformatf("%s_drce_k%0d", tag, k), mem_ce, cpu_on);
        issued.push_back(-1);
      end
      exp_we = (k >= 2) && (issued[k-2] >= 0);
      check($sformatf("%s_lbwe_k%0d", tag, k), lb_we, exp_we);
      if (exp_we) begin
        check($sformatf("%s_lbaddr_k%0d", tag, k), lb_addr, issued[k-2]);
        check($sformatf("%s_lbbank_k%0d", tag, k), lb_bank, bank);
        check($sformatf("%s_lbdata_k%0d", tag, k), lb_wdata, mem_fn(base + AW'(issued[k-2])));
      end
    end
    check({tag, "_nreads"}, n_rd, WPL);
    check({tag, "_nlbwe"}, n_lb, WPL);
    check({tag, "_ncpu"}, n_cpu, n_cpu_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ce", mem_ce, 0);
    check("rst_lbwe", lb_we, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_ovr", overrun_err, 0);
    check("rst_dbank", disp_bank, 0);
    check("rst_rdy", cpu_ready, 1);
    @(posedge clk); #1 reset = 1'b0;

    // Line 0 visible: prefetch line 1 (words 40..79) into bank 1.
    @(posedge clk); #1 addr_y_valid = 1'b1; addr_y = 9'd0;
    @(negedge clk);
    check("l1_trig_busy", fetch_busy, 0);
    check("l1_trig_ce", mem_ce, 0);
    burst("l1", 18'd40, 1'b1, 1'b0, 40, 0);
    check("l1_ovr", overrun_err, 0);
    check("l1_dbank", disp_bank, 0);

    // Line 1 with CPU pressure: line 2 (80..119) into bank 0, 13 CPU slots in 53 cycles.
    @(posedge clk); #1 addr_y = 9'd1; cpu_valid = 1'b1; cpu_addr = 18'h100; cpu_wdata = 16'h00C3;
    burst("cpu", 18'd80, 1'b0, 1'b1, 53, 13);
    check("cpu_dbank", disp_bank, 1);

    // Last visible line: no fetch.
    @(posedge clk); #1 cpu_valid = 1'b0; addr_y = 9'd479;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("last_busy_%0d", i), fetch_busy, 0);
      check($sformatf("last_ce_%0d", i), mem_ce, 0);
      @(posedge clk);
    end
    check("last_dbank", disp_bank, 1);

    // Frame end: line 0 (0..39) into bank 0.
    #1 addr_y_valid = 1'b0;
    @(negedge clk);
    check("fe_trig_busy", fetch_busy, 0);
    burst("fe", 18'd0, 1'b0, 1'b0, 40, 0);
    check("fe_dbank", disp_bank, 0);

    // Overrun: line 6 (base 240) abandoned at idx 10 for line 7 (base 280, bank 1).
    @(posedge clk); #1 addr_y_valid = 1'b1; addr_y = 9'd5;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("ovr_k9_ce", mem_ce, 1);
    check("ovr_k9_addr", mem_addr, 32'd249);
    @(posedge clk); #1 addr_y = 9'd6;
    @(negedge clk);
    check("ovr_trig_ce", mem_ce, 0);
    check("ovr_trig_lbwe", lb_we, 0);
    check("ovr_trig_busy", fetch_busy, 1);
    check("ovr_pre_flag", overrun_err, 0);
    burst("ovr", 18'd280, 1'b1, 1'b0, 40, 0);
    check("ovr_flag", overrun_err, 1);

    // Reset mid-fetch of line 8 (base 320).
    @(posedge clk); #1 addr_y = 9'd7;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mrst_k5_addr", mem_addr, 32'd325);
    @(posedge clk); #1 reset = 1'b1; addr_y_valid = 1'b0;
    #1;
    check("mrst_ce", mem_ce, 0);
    check("mrst_lbwe", lb_we, 0);
    check("mrst_busy", fetch_busy, 0);
    check("mrst_ovr", overrun_err, 0);
    check("mrst_dbank", disp_bank, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mrst_post_lbwe_%0d", i), lb_we, 0);
      check($sformatf("mrst_post_ce_%0d", i), mem_ce, 0);
      @(posedge clk);
    end
    #1 addr_y_valid = 1'b1; addr_y = 9'd7;
    @(negedge clk);
    check("rf_trig_busy", fetch_busy, 0);
    burst("rf", 18'd320, 1'b0, 1'b0, 40, 0);
    check("rf_ovr", overrun_err, 0);
    check("rf_dbank", disp_bank, 1);

    // Idle CPU writes pass straight through.
    @(posedge clk); #1 cpu_valid = 1'b1; cpu_addr = 18'h3FFFF; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check("idle_rdy0", cpu_ready, 1);
    check("idle_ce0", mem_ce, 1);
    check("idle_we0", mem_we, 1);
    check("idle_addr0", mem_addr, 32'h3FFFF);
    check("idle_data0", mem_wdata, 32'hBEEF);
    @(posedge clk); #1 cpu_addr = 18'h00ABC; cpu_wdata = 16'h1234;
    @(negedge clk);
    check("idle_rdy1", cpu_ready, 1);
    check("idle_we1", mem_we, 1);
    check("idle_addr1", mem_addr, 32'h00ABC);
    check("idle_data1", mem_wdata, 32'h1234);
    check("idle_busy1", fetch_busy, 0);
    @(posedge clk); #1 cpu_valid = 1'b0;
    @(negedge clk);
    check("idle_ce2", mem_ce, 0);
    check("idle_rdy2", cpu_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
